// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle between the multiplier product stream, the accumulator and its result consumer.
interface dot_product_accumulator_if #(
  parameter int WIDTH = 4,
  parameter int ACCW  = 2*WIDTH+4
);
  logic [2*WIDTH-1:0] p;
  logic               p_valid;
  logic               p_ready;
  logic               flush;
  logic [ACCW-1:0]    sum;
  logic               sum_valid;
  logic               sum_ready;
  logic [3:0]         cnt;

  modport master (
    output p, p_valid, flush, sum_ready,
    input  p_ready, sum, sum_valid, cnt
  );

  modport slave (
    input  p, p_valid, flush, sum_ready,
    output p_ready, sum, sum_valid, cnt
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums LEN unsigned products into one dot-product result and holds it until the consumer takes it.
// state | meaning
// ACCUM | collecting products into the partial sum
// HOLD  | completed result presented on sum, waiting for sum_ready
module dot_product_accumulator #(
  parameter int WIDTH = 4,
  parameter int LEN   = 4,
  parameter int ACCW  = 2*WIDTH+4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dot_product_accumulator_if.slave   bus
);
  localparam int PW = 2*WIDTH;
  localparam logic [3:0] LAST = 4'(LEN-1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] sum_q, sum_d;
  logic            sum_valid_q, sum_valid_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   p_w;
  logic [ACCW-1:0] p_ext;
  logic            p_ready;
  logic            accept;

  assign p_w   = bus.p;
  assign p_ext = ACCW'(p_w);

  assign p_ready = (state_q == ACCUM) ? !bus.flush : bus.sum_ready;
  assign accept  = bus.p_valid && p_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      ACCUM: begin
        if (bus.flush) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == LAST) begin
            sum_d       = acc_q + p_ext;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = acc_q + p_ext;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (bus.sum_ready) begin
          // A product arriving with the consumer's take starts the next sum immediately.
          if (accept && LEN > 1) begin
            acc_d       = p_ext;
            cnt_d       = 4'd1;
            sum_valid_d = 1'b0;
            state_d     = ACCUM;
          end else if (accept) begin
            sum_d = p_ext;
          end else begin
            sum_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign bus.p_ready   = p_ready;
  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.cnt       = cnt_q;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized and directed checks of dot_product_accumulator against a queue-based reference model.
module tb_dot_product_accumulator;
  localparam int WIDTH = 4;
  localparam int LEN   = 4;
  localparam int ACCW  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_product_accumulator_if #(.WIDTH(WIDTH), .ACCW(ACCW)) bus ();

  dot_product_accumulator #(.WIDTH(WIDTH), .LEN(LEN), .ACCW(ACCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: products accepted into the open group, pending result, last result
  int unsigned     part[$];
  logic            pending = 1'b0;
  logic [ACCW-1:0] sum_reg = '0;
  int              model_taken = 0;
  int              dut_taken = 0;

  always @(posedge clk)
    if (rst_n && bus.sum_valid && bus.sum_ready) dut_taken++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic exp_ready();
    return pending ? bus.sum_ready : !bus.flush;
  endfunction

  task automatic model_reset();
    part.delete();
    pending = 1'b0;
    sum_reg = '0;
  endtask

  task automatic model_step();
    logic        acc, was_hold;
    int unsigned t;
    if (!rst_n) return;
    acc      = bus.p_valid && exp_ready();
    was_hold = pending;
    if (pending && bus.sum_ready) begin
      pending = 1'b0;
      model_taken++;
    end
    if (!was_hold && bus.flush) part.delete();
    else if (acc) begin
      part.push_back(int'(bus.p));
      if (part.size() == LEN) begin
        t = 0;
        foreach (part[i]) t += part[i];
        sum_reg = ACCW'(t);
        pending = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic check_outputs();
    check_val("sum_valid", 32'(bus.sum_valid), 32'(pending));
    check_val("cnt", 32'(bus.cnt), 32'(part.size()));
    check_val("sum", 32'(bus.sum), 32'(sum_reg));
  endtask

  // called just after a falling edge; drives inputs, checks p_ready, clocks once, checks registers
  task automatic tick(input logic pv, input logic [7:0] pval, input logic sr, input logic fl);
    bus.p_valid = pv; bus.p = pval; bus.sum_ready = sr; bus.flush = fl;
    #1;
    check_val("p_ready", 32'(bus.p_ready), 32'(exp_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_cnt", 32'(bus.cnt), 32'd0);
    check_val("rst_sum", 32'(bus.sum), 32'd0);
    check_val("rst_valid", 32'(bus.sum_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] a, b;
    bus.p = '0; bus.p_valid = 1'b0; bus.sum_ready = 1'b0; bus.flush = 1'b0;
    #3;
    check_val("reset_sum", 32'(bus.sum), 32'd0);
    check_val("reset_valid", 32'(bus.sum_valid), 32'd0);
    check_val("reset_cnt", 32'(bus.cnt), 32'd0);
    check_val("reset_p_ready", 32'(bus.p_ready), 32'd1);
    @(negedge clk);
    tick(1'b1, 8'd9, 1'b0, 1'b0);          // no capture while in reset
    check_val("reset_no_capture", 32'(bus.cnt), 32'd0);
    rst_n = 1'b1;

    // 6+10+15+1, result valid for exactly one cycle
    tick(1'b1, 8'd6, 1'b1, 1'b0);
    tick(1'b1, 8'd10, 1'b1, 1'b0);
    tick(1'b1, 8'd15, 1'b1, 1'b0);
    tick(1'b1, 8'd1, 1'b1, 1'b0);
    check_val("sum_32", 32'(bus.sum), 32'd32);
    check_val("valid_32", 32'(bus.sum_valid), 32'd1);
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    check_val("valid_one_cycle", 32'(bus.sum_valid), 32'd0);

    // 4 x 225 without wrap, cnt steps 1,2,3,0
    tick(1'b1, 8'd225, 1'b0, 1'b0); check_val("cnt_step1", 32'(bus.cnt), 32'd1);
    tick(1'b1, 8'd225, 1'b0, 1'b0); check_val("cnt_step2", 32'(bus.cnt), 32'd2);
    tick(1'b1, 8'd225, 1'b0, 1'b0); check_val("cnt_step3", 32'(bus.cnt), 32'd3);
    tick(1'b1, 8'd225, 1'b0, 1'b0); check_val("cnt_step0", 32'(bus.cnt), 32'd0);
    check_val("sum_900", 32'(bus.sum), 32'd900);

    // back-pressure with p_valid held, then simultaneous take and accept of 7
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'd33, 1'b0, 1'b0);
      check_val("hold_sum", 32'(bus.sum), 32'd900);
      check_val("hold_cnt", 32'(bus.cnt), 32'd0);
    end
    tick(1'b1, 8'd7, 1'b1, 1'b0);
    check_val("take_valid", 32'(bus.sum_valid), 32'd0);
    check_val("take_cnt", 32'(bus.cnt), 32'd1);
    tick(1'b1, 8'd1, 1'b0, 1'b0);
    tick(1'b1, 8'd1, 1'b0, 1'b0);
    tick(1'b1, 8'd1, 1'b0, 1'b0);
    check_val("partial7_sum", 32'(bus.sum), 32'd10);
    tick(1'b0, 8'd0, 1'b1, 1'b0);

    // flush discards 3,4 and the product offered alongside it
    tick(1'b1, 8'd3, 1'b0, 1'b0);
    tick(1'b1, 8'd4, 1'b0, 1'b0);
    tick(1'b1, 8'd9, 1'b0, 1'b1);
    check_val("flush_cnt", 32'(bus.cnt), 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b1, 8'd1, 1'b0, 1'b0);
    check_val("sum_4", 32'(bus.sum), 32'd4);
    tick(1'b0, 8'd0, 1'b1, 1'b1);           // flush in HOLD is ignored, take proceeds
    check_val("flush_hold_sum", 32'(bus.sum), 32'd4);

    // reset mid-accumulation and while a result is pending
    tick(1'b1, 8'd5, 1'b0, 1'b0);
    tick(1'b1, 8'd5, 1'b0, 1'b0);
    pulse_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'd3, 1'b0, 1'b0);
    check_val("sum_12", 32'(bus.sum), 32'd12);
    pulse_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'd2, 1'b0, 1'b0);
    check_val("sum_8", 32'(bus.sum), 32'd8);
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    model_taken = 0;
    @(negedge clk);
    dut_taken = 0;

    // randomized multiplier output stream with gaps on both sides
    for (int i = 0; i < 400; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 99) < 70, 8'(a * b),
           $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 4);
    end
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    check_val("results_taken", 32'(dut_taken), 32'(model_taken));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
